// File: rtl/alu_share_arb_if.sv
// Handshake bundle for alu_share_arb: two request channels into one shared ALU
// and a single tagged response channel.
interface alu_share_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic [3:0]  req0_sel;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic [3:0]  req1_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_err;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_sel,
        input  req1_valid, req1_op1, req1_op2, req1_sel,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_sel,
        output req1_valid, req1_op1, req1_op2, req1_sel,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one 32-bit ALU between two requesters, with a single
// registered, tagged response slot that can drain and refill in the same cycle.
module alu_share_arb #(
    parameter bit RR_INIT        = 1'b0,
    parameter bit ERR_ON_ILLEGAL = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    alu_share_arb_if.slave bus,
    output logic           busy
);
    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;

    logic        slot_free;
    logic        gnt0, gnt1, accept;
    logic [31:0] op1, op2;
    logic [3:0]  sel;
    logic [4:0]  shamt;
    logic [5:0]  rol_amt;
    logic [63:0] dbl;
    logic [31:0] alu_res;
    logic        alu_ill;

    assign slot_free = (state_q == StEmpty) | bus.rsp_ready;

    // Readies are forced low while reset is held, even though the slot reads empty.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (slot_free && reset) begin
            if (bus.req0_valid && (!bus.req1_valid || (ptr_q == 1'b0))) begin
                gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign accept         = gnt0 | gnt1;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    assign op1 = gnt1 ? bus.req1_op1 : bus.req0_op1;
    assign op2 = gnt1 ? bus.req1_op2 : bus.req0_op2;
    assign sel = gnt1 ? bus.req1_sel : bus.req0_sel;

    // Rotates shift a doubled operand; rol by n is ror by 32-n (n=0 gives op2).
    always_comb begin
        shamt   = op1[4:0];
        rol_amt = 6'd32 - {1'b0, shamt};
        dbl     = {op2, op2};
        alu_res = '0;
        alu_ill = 1'b0;
        case (sel)
            4'd0:    alu_res = op1;
            4'd2:    alu_res = op1 + op2;
            4'd3:    alu_res = op1 - op2;
            4'd4:    alu_res = op1 & op2;
            4'd5:    alu_res = op1 | op2;
            4'd6:    alu_res = op1 ^ op2;
            4'd7:    alu_res = ~(op1 | op2);
            4'd8:    alu_res = op2 >> shamt;
            4'd9:    alu_res = $signed(op2) >>> shamt;
            4'd10:   alu_res = op2 << shamt;
            4'd11:   alu_res = 32'(dbl >> shamt);
            4'd12:   alu_res = {31'b0, $signed(op1) < $signed(op2)};
            4'd13:   alu_res = {31'b0, op1 < op2};
            4'd14:   alu_res = 32'(dbl >> rol_amt);
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        result_d = result_q;
        err_d    = err_q;
        if (accept) begin
            state_d  = StFull;
            ptr_d    = ~gnt1;
            id_d     = gnt1;
            result_d = alu_res;
            err_d    = alu_ill & ERR_ON_ILLEGAL;
        end else if (bus.rsp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StEmpty;
            ptr_q    <= RR_INIT;
            id_q     <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.rsp_valid  = (state_q == StFull);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;
    assign busy           = (state_q == StFull);
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: constant-vector tests plus a per-requester scoreboard
// fed from an independent ALU model at every handshake.
module tb_alu_share_arb;
    localparam bit ErrOnIllegal = 1'b1;
    localparam int NumVec = 14;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    alu_share_arb_if bus ();

    alu_share_arb #(
        .RR_INIT        (1'b0),
        .ERR_ON_ILLEGAL (ErrOnIllegal)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic        err;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[NumVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t r;
        int   sh;
        sh    = int'(a[4:0]);
        r.res = 32'd0;
        r.err = 1'b0;
        case (sel)
            4'd0:  r.res = a;
            4'd2:  r.res = a + b;
            4'd3:  r.res = a - b;
            4'd4:  r.res = a & b;
            4'd5:  r.res = a | b;
            4'd6:  r.res = a ^ b;
            4'd7:  r.res = ~(a | b);
            4'd8:  r.res = b >> sh;
            4'd9:  r.res = $signed(b) >>> sh;
            4'd10: r.res = b << sh;
            4'd11: r.res = (sh == 0) ? b : ((b >> sh) | (b << (32 - sh)));
            4'd12: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: r.res = (a < b) ? 32'd1 : 32'd0;
            4'd14: r.res = (sh == 0) ? b : ((b << sh) | (b >> (32 - sh)));
            default: r.err = ErrOnIllegal;
        endcase
        return r;
    endfunction

    // Pop before push so a drain+refill of the same requester stays in order.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b1) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if ((bus.rsp_id == 1'b0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got response id=%0d result=0x%08h, expected none",
                             bus.rsp_id, bus.rsp_result);
                end else begin
                    e = (bus.rsp_id == 1'b0) ? q0.pop_front() : q1.pop_front();
                    check("sb_result", bus.rsp_result, e.res);
                    check("sb_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                end
            end
            if (bus.req0_valid && bus.req0_ready)
                q0.push_back(model(bus.req0_sel, bus.req0_op1, bus.req0_op2));
            if (bus.req1_valid && bus.req1_ready)
                q1.push_back(model(bus.req1_sel, bus.req1_op1, bus.req1_op2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_sel = sel; bus.req0_op1 = a; bus.req0_op2 = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_sel = sel; bus.req1_op1 = a; bus.req1_op2 = b;
        end
    endtask

    task automatic release_port(input int p);
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_ready(input int p, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((((p == 0) ? bus.req0_ready : bus.req1_ready) !== 1'b1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL %s: ready stayed 0 for 20 cycles, expected 1", name);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic a0, a1;
        vecs[0]  = '{4'd0,  32'hDEADBEEF, 32'h00000001, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{4'd1,  32'h00000005, 32'h00000006, 32'h00000000, 1'b1};
        vecs[2]  = '{4'd2,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0};
        vecs[3]  = '{4'd5,  32'h00000001, 32'h80000000, 32'h80000001, 1'b0};
        vecs[4]  = '{4'd7,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 1'b0};
        vecs[5]  = '{4'd8,  32'h00000008, 32'h80000000, 32'h00800000, 1'b0};
        vecs[6]  = '{4'd9,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
        vecs[7]  = '{4'd10, 32'h00000024, 32'h00000001, 32'h00000010, 1'b0};
        vecs[8]  = '{4'd11, 32'h00000000, 32'h0000A5A5, 32'h0000A5A5, 1'b0};
        vecs[9]  = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        vecs[10] = '{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[11] = '{4'd14, 32'h00000000, 32'h00001234, 32'h00001234, 1'b0};
        vecs[12] = '{4'd14, 32'h00000008, 32'h12345678, 32'h34567812, 1'b0};
        vecs[13] = '{4'd15, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1};

        // Reset held with both requesters asserting.
        reset = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(0, 4'd2, 32'd1, 32'd1);
        drive(1, 4'd2, 32'd1, 32'd1);
        @(negedge clk);
        check("rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, bus.req1_ready}, 32'd0);
        check("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_id", {31'b0, bus.rsp_id}, 32'd0);
        check("rst_result", bus.rsp_result, 32'd0);
        check("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        release_port(0);
        release_port(1);
        tick();
        reset = 1'b1;

        // Single add from requester 0.
        bus.rsp_ready = 1'b1;
        drive(0, 4'd2, 32'd5, 32'd7);
        @(negedge clk);
        check("single_ready0", {31'b0, bus.req0_ready}, 32'd1);
        check("single_ready1", {31'b0, bus.req1_ready}, 32'd0);
        tick();
        release_port(0);
        @(negedge clk);
        check("single_valid", {31'b0, bus.rsp_valid}, 32'd1);
        check("single_id", {31'b0, bus.rsp_id}, 32'd0);
        check("single_result", bus.rsp_result, 32'd12);
        check("single_err", {31'b0, bus.rsp_err}, 32'd0);
        check("single_busy", {31'b0, busy}, 32'd1);

        // Contention: grants alternate 0,1,0,1 from RR_INIT=0.
        do_reset();
        drive(0, 4'd3, 32'd3, 32'd10);
        drive(1, 4'd11, 32'd4, 32'h0000000F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("cont_gnt0_%0d", i), {31'b0, bus.req0_ready}, {31'b0, (i % 2) == 0});
            check($sformatf("cont_gnt1_%0d", i), {31'b0, bus.req1_ready}, {31'b0, (i % 2) == 1});
            if (i > 0) begin
                check($sformatf("cont_result_%0d", i), bus.rsp_result,
                      ((i % 2) == 1) ? 32'hFFFFFFF9 : 32'hF0000000);
                check($sformatf("cont_id_%0d", i), {31'b0, bus.rsp_id}, {31'b0, (i % 2) == 0});
            end
            tick();
        end
        release_port(0);
        release_port(1);
        @(negedge clk);
        check("cont_last_id", {31'b0, bus.rsp_id}, 32'd1);
        check("cont_last_result", bus.rsp_result, 32'hF0000000);
        tick();

        // Backpressure: full slot stalls both requesters, then drain+refill.
        bus.rsp_ready = 1'b0;
        drive(0, 4'd6, 32'hFF00FF00, 32'h0F0F0F0F);
        wait_ready(0, "bp_accept");
        tick();
        drive(0, 4'd4, 32'hFFFF0000, 32'h12345678);
        drive(1, 4'd5, 32'h000000F0, 32'h00000F00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("bp_ready0", {31'b0, bus.req0_ready}, 32'd0);
            check("bp_ready1", {31'b0, bus.req1_ready}, 32'd0);
            check("bp_result", bus.rsp_result, 32'hF00FF00F);
            check("bp_id", {31'b0, bus.rsp_id}, 32'd0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("refill_ready1", {31'b0, bus.req1_ready}, 32'd1);
        check("refill_ready0", {31'b0, bus.req0_ready}, 32'd0);
        tick();
        release_port(1);
        @(negedge clk);
        check("refill_valid", {31'b0, bus.rsp_valid}, 32'd1);
        check("refill_id", {31'b0, bus.rsp_id}, 32'd1);
        check("refill_result", bus.rsp_result, 32'h00000FF0);
        check("refill_next_ready0", {31'b0, bus.req0_ready}, 32'd1);
        tick();
        release_port(0);
        @(negedge clk);
        check("refill2_id", {31'b0, bus.rsp_id}, 32'd0);
        check("refill2_result", bus.rsp_result, 32'h12340000);
        tick();

        // Constant vector table, alternating requesters.
        for (int i = 0; i < NumVec; i++) begin
            drive(i % 2, vecs[i].sel, vecs[i].op1, vecs[i].op2);
            wait_ready(i % 2, $sformatf("vec%0d_accept", i));
            tick();
            release_port(i % 2);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'b0, bus.rsp_valid}, 32'd1);
            check($sformatf("vec%0d_id", i), {31'b0, bus.rsp_id}, 32'(i % 2));
            check($sformatf("vec%0d_result", i), bus.rsp_result, vecs[i].res);
            check($sformatf("vec%0d_err", i), {31'b0, bus.rsp_err}, {31'b0, vecs[i].err});
            tick();
        end

        // Random traffic with random backpressure, checked by the scoreboard.
        for (int c = 0; c < 80; c++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!bus.req0_valid && ($urandom_range(0, 1) == 1))
                drive(0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            if (!bus.req1_valid && ($urandom_range(0, 1) == 1))
                drive(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            check("rand_onehot", {31'b0, bus.req0_ready & bus.req1_ready}, 32'd0);
            tick();
            if (a0) release_port(0);
            if (a1) release_port(1);
        end
        bus.rsp_ready = 1'b1;
        for (int n = 0; (n < 20) && ((q0.size() + q1.size()) != 0); n++) tick();
        check("rand_q0_empty", q0.size(), 32'd0);
        check("rand_q1_empty", q1.size(), 32'd0);
        release_port(0);
        release_port(1);
        tick();
        tick();

        // Reset while full discards the result; pending req1 is granted after release.
        bus.rsp_ready = 1'b0;
        drive(0, 4'd2, 32'd1, 32'd1);
        wait_ready(0, "rst_full_accept");
        tick();
        release_port(0);
        drive(1, 4'd10, 32'd4, 32'd1);
        @(negedge clk);
        check("rst_full_valid", {31'b0, bus.rsp_valid}, 32'd1);
        check("rst_full_ready1", {31'b0, bus.req1_ready}, 32'd0);
        #2;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("rst_async_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_async_busy", {31'b0, busy}, 32'd0);
        check("rst_async_ready1", {31'b0, bus.req1_ready}, 32'd0);
        tick();
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready1", {31'b0, bus.req1_ready}, 32'd1);
        check("post_rst_ready0", {31'b0, bus.req0_ready}, 32'd0);
        tick();
        release_port(1);
        @(negedge clk);
        check("post_rst_valid", {31'b0, bus.rsp_valid}, 32'd1);
        check("post_rst_id", {31'b0, bus.rsp_id}, 32'd1);
        check("post_rst_result", bus.rsp_result, 32'd16);
        tick();
        tick();
        check("final_q0_empty", q0.size(), 32'd0);
        check("final_q1_empty", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one 32-bit ALU datapath between two requesters: port 0 is the EX-stage issue, and port 1 is an auxiliary sequencer such as address generation or a debug unit.
- Each requester presents operands and a 4-bit op select with a valid/ready handshake.
- The block arbitrates round-robin, drives the single internal ALU instance, and returns a registered, tagged result through one response channel with valid/ready backpressure.

Parameters:
- RR_INIT, 0, requester that holds priority after reset (0 or 1).
- ERR_ON_ILLEGAL, 1, when 1 an illegal sel raises rsp_err; when 0 it returns result 0 silently.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op1  in  32  operand 1 (shift amount source for shifts and rotates)
- req0_op2  in  32  operand 2
- req0_sel  in  4  op code, using the same encoding as the datapath ALU
- req1_valid / req1_ready / req1_op1 / req1_op2 / req1_sel  same as port 0, for requester 1
- rsp_valid  out  1  result register holds a valid result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  requester that issued the result
- rsp_result  out  32  ALU result
- rsp_err  out  1  operation had an illegal sel
- busy  out  1  equals rsp_valid; used for pipeline stall logic

Behaviour:
- Reset (reset=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
  - Priority pointer = RR_INIT.
  - req0_ready=req1_ready=0 while reset is held.
- Legal sel values: 0 (pass op1), 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 nor, 8 srl, 9 sra, 10 sll, 11 ror, 12 slt signed, 13 sltu, 14 rol.
  - Shifts and rotates: op2 is shifted by op1[4:0].
  - Rotates with amount 0 return op2 unchanged.
  - slt/sltu return {31'b0, flag}.
  - Arithmetic wraps modulo 2^32; there are no overflow flags.
- Illegal sel values are 1 and 15:
  - rsp_result=0.
  - rsp_err=ERR_ON_ILLEGAL.
  - The operation is still accepted and returns a response.
- The ALU is combinational and is driven only by the granted requester's operands. The result is captured into the response register at the acceptance edge.
- Slot availability: slot_free = ~rsp_valid | rsp_ready. A full register that drains this cycle can be refilled in the same cycle.
- Grant rules (combinational, within a cycle):
  - No grant when slot_free=0; both ready signals are 0.
  - Only one valid requester: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted; the other sees ready=0.
  - At most one ready is 1 per cycle.
  - Ready does not depend on the requester's own valid beyond the grant; requesters hold all inputs stable until accepted.
- Acceptance (reqN_valid & reqN_ready at the clock edge):
  - rsp_valid<=1, rsp_id<=N, rsp_result/rsp_err load.
  - The priority pointer moves to the other requester.
  - The pointer moves on every grant, contested or not, giving a fairness bound of at most one wait per contest.
- Drain without refill (rsp_valid & rsp_ready, no acceptance): rsp_valid<=0. rsp_result/rsp_id/rsp_err hold their last values.
- Stall (rsp_valid=1, rsp_ready=0): the response outputs hold stable and the pointer does not move.
- Latency and throughput:
  - Accept-to-rsp_valid is 1 cycle.
  - Throughput is 1 op/cycle while rsp_ready=1.
- States:
  - EMPTY (rsp_valid=0) moves to FULL on acceptance.
  - FULL stays FULL on drain+accept or on stall.
  - FULL moves to EMPTY on drain with no request.
- Reset during FULL discards the pending result with no response. A requester's held request is re-arbitrated after reset release, starting from RR_INIT.

Test Plan:
- Reset then single op: req0 op1=5, op2=7, sel=2 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_err=0.
- Contention with RR_INIT=0, both valid back-to-back, rsp_ready=1:
  - req0 sel=3 (op1=3, op2=10) → result 0xFFFFFFF9, rsp_id=0.
  - req1 sel=11 (op1=4, op2=0x0000000F) → result 0xF0000000, rsp_id=1.
  - Grants alternate 0,1,0,1 on consecutive cycles.
- Backpressure: hold rsp_ready=0 with rsp_valid=1 for 3 cycles → both ready=0, outputs stable; raise rsp_ready with req1 valid → drain and refill in the same cycle, rsp_valid stays 1.
- Ops check:
  - sel=9, op1=4, op2=0x80000000 → 0xF8000000.
  - sel=12, op1=0xFFFFFFFF, op2=1 → 1.
  - sel=13 with the same operands → 0.
  - sel=14, op1=0, op2=0x1234 → 0x1234.
- Illegal sel=15 with ERR_ON_ILLEGAL=1 → rsp_result=0, rsp_err=1, response still delivered.
- Assert reset=0 mid-FULL while rsp_ready=0 → rsp_valid drops immediately (asynchronously); after release, a pending req1 with RR_INIT=0 and req0 idle is granted next.
